// File: rtl/btn_debounce_reader.sv
// btn_debounce_reader
//   Synchronises and debounces WIDTH raw pad inputs. Each channel yields a
//   clean level, a one-cycle rise strobe and a one-cycle fall strobe, with
//   optional per-channel press counters.
//
//   Configuration macro: BTN_DEBOUNCE_PRESS_CNT_EN
//     defined   -> per-channel press counters are built; cnt_clr clears them
//     undefined -> press_cnt is tied to 0 and cnt_clr is ignored
//
//   Ports:
//     clk        fabric clock
//     rst_n      asynchronous active-low reset
//     btn_raw    raw asynchronous pad inputs, active-high
//     cnt_clr    synchronous clear of all press counters
//     btn_state  debounced level per channel
//     btn_rise   one-cycle strobe on debounced 0->1
//     btn_fall   one-cycle strobe on debounced 1->0
//     press_cnt  press counters, channel i at [i*CNT_W +: CNT_W]
module btn_debounce_reader #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       btn_raw,
    input  logic                   cnt_clr,
    output logic [WIDTH-1:0]       btn_state,
    output logic [WIDTH-1:0]       btn_rise,
    output logic [WIDTH-1:0]       btn_fall,
    output logic [WIDTH*CNT_W-1:0] press_cnt
);

    localparam int unsigned       STAB_W    = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]             sync1_q, sync1_d;
    logic [WIDTH-1:0]             sync_q,  sync_d;
    logic [WIDTH-1:0]             state_q, state_d;
    logic [WIDTH-1:0]             rise_q,  rise_d;
    logic [WIDTH-1:0]             fall_q,  fall_d;
    logic [WIDTH-1:0][STAB_W-1:0] stab_q,  stab_d;

    always_comb begin
        sync1_d = btn_raw;
        sync_d  = sync1_q;
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        stab_d  = stab_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == state_q[i]) begin
                stab_d[i] = '0;
            end else if (stab_q[i] != STAB_LAST) begin
                stab_d[i] = stab_q[i] + STAB_W'(1);
            end else begin
                // Terminal count: accept the new level and strobe the edge.
                stab_d[i]  = '0;
                state_d[i] = sync_q[i];
                rise_d[i]  = sync_q[i];
                fall_d[i]  = ~sync_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            stab_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stab_q  <= stab_d;
        end
    end

    assign btn_state = state_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

`ifdef BTN_DEBOUNCE_PRESS_CNT_EN
    logic [WIDTH-1:0][CNT_W-1:0] press_q, press_d;

    // Counters key off rise_d so they update on the same edge as btn_rise.
    always_comb begin
        press_d = press_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_clr) begin
                press_d[i] = rise_d[i] ? CNT_W'(1) : '0;
            end else if (rise_d[i]) begin
                press_d[i] = press_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= '0;
        end else begin
            press_q <= press_d;
        end
    end

    assign press_cnt = press_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign press_cnt      = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_reader.sv
module tb_btn_debounce_reader;

    localparam int unsigned W  = 4;
    localparam int unsigned S  = 4;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  btn_raw;
    logic          cnt_clr;
    logic [W-1:0]  btn_state, btn_rise, btn_fall;
    logic [W*CW-1:0] press_cnt;

    btn_debounce_reader #(.WIDTH(W), .STABLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .cnt_clr   (cnt_clr),
        .btn_state (btn_state),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]    st;
        logic [W-1:0]    ri;
        logic [W-1:0]    fa;
        logic [W*CW-1:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: edge-indexed history of pad samples. A channel flips
    // at edge n when the S samples taken at edges n-1-S .. n-2 all differ from
    // the current level and every one of them was observed after the last flip.
    logic [W-1:0]     samp_q[$];
    int               n_edge   = 0;
    int               base     = 0;
    int               flip_at [W];
    logic [W-1:0]     m_state  = '0;
    logic [CW-1:0]    m_press [W];

    function automatic logic get_s(int k, int ch);
        if (k < 0 || k < base) return 1'b0;
        return samp_q[k][ch];
    endfunction

    function automatic void model_edge(logic [W-1:0] raw, logic clr, logic rst);
        exp_t e;
        logic all_diff;
        e = '0;
        samp_q.push_back(raw);
        if (!rst) begin
            m_state = '0;
            base    = n_edge + 1;
            for (int ch = 0; ch < W; ch++) begin
                flip_at[ch] = -1000;
                m_press[ch] = '0;
            end
        end else begin
            for (int ch = 0; ch < W; ch++) begin
                all_diff = (n_edge > flip_at[ch] + int'(S) - 1);
                for (int k = n_edge - 1 - int'(S); k <= n_edge - 2; k++)
                    if (get_s(k, ch) == m_state[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_state[ch] = ~m_state[ch];
                    flip_at[ch] = n_edge;
                    e.ri[ch]    = m_state[ch];
                    e.fa[ch]    = ~m_state[ch];
                end
`ifdef BTN_DEBOUNCE_PRESS_CNT_EN
                if (clr)           m_press[ch] = e.ri[ch] ? CW'(1) : '0;
                else if (e.ri[ch]) m_press[ch] = m_press[ch] + CW'(1);
`endif
            end
        end
        e.st = m_state;
        for (int ch = 0; ch < W; ch++) e.pc[ch*CW +: CW] = m_press[ch];
        exp_q.push_back(e);
        n_edge++;
    endfunction

    // Drive inputs for the next edge, record the expectation, advance.
    task automatic step(input logic [W-1:0] raw, input logic clr, input logic rst);
        btn_raw = raw;
        cnt_clr = clr;
        rst_n   = rst;
        model_edge(raw, clr, rst);
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [W-1:0] raw, input int cycles);
        for (int i = 0; i < cycles; i++) step(raw, 1'b0, 1'b1);
    endtask

    // Monitor: every edge presents a full output vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (btn_state !== e.st) begin
                    miscompares++;
                    $display("FAIL btn_state @%0t got %h want %h", $time, btn_state, e.st);
                end
                if (btn_rise !== e.ri) begin
                    miscompares++;
                    $display("FAIL btn_rise @%0t got %h want %h", $time, btn_rise, e.ri);
                end
                if (btn_fall !== e.fa) begin
                    miscompares++;
                    $display("FAIL btn_fall @%0t got %h want %h", $time, btn_fall, e.fa);
                end
                if (press_cnt !== e.pc) begin
                    miscompares++;
                    $display("FAIL press_cnt @%0t got %h want %h", $time, press_cnt, e.pc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] raw;
        int           left [W];

        for (int ch = 0; ch < W; ch++) begin
            flip_at[ch] = -1000;
            m_press[ch] = '0;
        end

        // Reset with all pads high, then release: pads register as presses.
        for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0);
        hold(4'hF, 10);
        hold(4'h0, 10);

        // Glitch on channel 0 shorter than the debounce window.
        hold(4'h1, 3);
        hold(4'h0, 10);

        // Clean press and release on channel 2.
        hold(4'h4, 20);
        hold(4'h0, 12);

        // Randomised per-channel hold lengths, straddling the window.
        raw = '0;
        for (int ch = 0; ch < W; ch++) left[ch] = 1;
        for (int i = 0; i < 800; i++) begin
            for (int ch = 0; ch < W; ch++) begin
                left[ch]--;
                if (left[ch] <= 0) begin
                    raw[ch]  = ~raw[ch];
                    left[ch] = int'($urandom_range(1, 2 * S + 2));
                end
            end
            step(raw, ($urandom_range(0, 29) == 0), 1'b1);
        end
        hold(4'h0, 10);

        // 256 clean presses on channel 1 wrap its counter.
        for (int p = 0; p < 256; p++) begin
            hold(4'h2, 7);
            hold(4'h0, 7);
        end
        // Press with cnt_clr landing exactly on the rise edge (S+1 after raise).
        hold(4'h2, int'(S) + 1);
        step(4'h2, 1'b1, 1'b1);
        hold(4'h2, 4);
        hold(4'h0, 8);

        // Reset mid-count on channel 3, then full latency from release.
        hold(4'h8, 4);
        step(4'h8, 1'b0, 1'b0);
        hold(4'h8, 12);
        hold(4'h0, 10);

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_debounce_reader.md
# btn_debounce_reader

Input-side companion to the LED counter demos on the EOS S3 fabric. It samples up to WIDTH raw push-button/switch pads, synchronises and debounces each one, and produces a clean level plus single-cycle rise/fall strobes. Optional per-channel press counters are included. It runs on a gclkbuff-buffered SoC system clock and feeds user logic that currently only drives outputs.

## Interface

Parameters:
- WIDTH, 4, number of independent input channels (1..16).
- STABLE_CYCLES, 50000, consecutive cycles a synchronised input must differ from the debounced state before the state flips (legal range 2..2^20).
- CNT_W, 8, width of each press counter.

Ports:
- clk  input  1  fabric clock, from gclkbuff on Sys_Clk0.
- rst_n  input  1  asynchronous, active-low reset.
- btn_raw  input  WIDTH  raw asynchronous pad inputs, active-high.
- cnt_clr  input  1  synchronous clear of all press counters.
- btn_state  output  WIDTH  debounced level per channel.
- btn_rise  output  WIDTH  one-cycle strobe: debounced 0->1.
- btn_fall  output  WIDTH  one-cycle strobe: debounced 1->0.
- press_cnt  output  WIDTH*CNT_W  press counters; channel i occupies [i*CNT_W +: CNT_W].

## Operation

- Every channel is independent and identical. There is no cross-channel state.
- Synchroniser: two flops per channel, sync1 and then sync_q. Both reset to 0.
- Stability counter per channel has width $clog2(STABLE_CYCLES) and resets to 0.
  - If sync_q == btn_state: counter <= 0.
  - If sync_q != btn_state and counter != STABLE_CYCLES-1: counter <= counter+1.
  - If sync_q != btn_state and counter == STABLE_CYCLES-1: btn_state <= sync_q, counter <= 0, and the matching strobe is asserted for exactly that cycle.
- A mismatch that ends before the terminal count restarts the count from 0. Glitches shorter than STABLE_CYCLES cycles are never reflected in btn_state.
- btn_rise and btn_fall are registered. They are never both high on one channel, and each is high for exactly one cycle per transition.
- Press counter (with the configuration macro defined): increments on btn_rise and wraps from 2^CNT_W-1 to 0.
  - cnt_clr with no btn_rise that cycle: counter <= 0.
  - cnt_clr in the same cycle as btn_rise: counter <= 1 (clear, then count).
- Reset mid-operation: all state returns asynchronously to reset values and any count in progress is discarded. No strobe is emitted on reset assertion or release.

## Timing

- Reset values:
  - btn_state = 0, btn_rise = 0, btn_fall = 0, press_cnt = 0.
  - Synchroniser flops = 0 and stability counters = 0.
- Latency: btn_raw is held at a new level from sampling edge E. btn_state and the strobe update on edge E+1+STABLE_CYCLES, which is STABLE_CYCLES+2 edges counting E.
- press_cnt updates on the same edge as btn_rise, so there is zero added latency.
- After reset release, a channel whose pad is already high produces btn_state=1 and btn_rise=1 at edge STABLE_CYCLES+2. This is treated as a press.
- Minimum debounced pulse: a level held ≥ STABLE_CYCLES+1 cycles always registers.

## Configuration

- BTN_DEBOUNCE_PRESS_CNT_EN:
  - Defined: press counters are built as described above.
  - Undefined: no counter flops are built, press_cnt is tied to 0, and cnt_clr is ignored. Debounce and strobe behaviour is identical in both builds.

## Test plan

Benches use WIDTH=4, STABLE_CYCLES=4, CNT_W=8 unless stated otherwise.

1. Reset: rst_n low with btn_raw=4'hF → all outputs 0. Release at edge 0 → btn_state=4'hF and btn_rise=4'hF for one cycle at edge 6, and press_cnt for each channel = 1 (macro defined).
2. Glitch reject: channel 0 goes high for 3 cycles then low → btn_state[0] stays 0, and no strobes on any channel.
3. Clean press/release: channel 2 is set high at edge 10 and low at edge 30. Required response:
   - btn_rise[2] at edge 16 and btn_fall[2] at edge 36.
   - Each strobe is exactly one cycle wide.
   - Other channels are unaffected.
4. Counter wrap and clear: 256 clean presses on channel 1 → press_cnt[15:8] returns to 0. Then assert cnt_clr in the btn_rise cycle → press_cnt[15:8] = 1.
5. Reset mid-count: channel 3 is mismatched with its counter at 2, and rst_n pulses low for 1 cycle. Required response: btn_state[3] = 0 and no strobe, and the full STABLE_CYCLES+2 latency applies again from release.
6. Macro off: repeat scenario 3 → identical btn_state and strobe timing, with press_cnt held at 0 throughout.
